// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the arbiter and the
// single-port memory. The arbiter sits on the slave side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [3:0]        dm_be;
    logic              dm_gnt;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  mem_rdata,
        output if_gnt, if_done, if_rdata,
        output dm_gnt, dm_done, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output busy
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output mem_rdata,
        input  if_gnt, if_done, if_rdata,
        input  dm_gnt, dm_done, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data
// load/store: grant, fixed-latency access, one-cycle done. Data wins unless fetch starves.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [3:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic              win_if_q, win_if_d;
    logic              pick_if;

    logic              if_gnt_d, if_done_d, dm_gnt_d, dm_done_d;
    logic              mem_en_d, mem_we_d, busy_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;
    logic [3:0]        mem_be_d;

    // Fetch only beats a pending data request once it has lost STARVE_LIMIT times in a row.
    assign pick_if = bus.if_req && (!bus.dm_req || starve_q == STARVE_MAX);

    always_comb begin
        // NOTE: every target gets a default first, so no path through the case infers a latch.
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        win_if_d    = win_if_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        mem_en_d    = bus.mem_en;
        mem_we_d    = bus.mem_we;
        mem_addr_d  = bus.mem_addr;
        mem_wdata_d = bus.mem_wdata;
        mem_be_d    = bus.mem_be;
        if_rdata_d  = bus.if_rdata;
        dm_rdata_d  = bus.dm_rdata;
        busy_d      = bus.busy;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d  = ACCESS;
                    lat_d    = LAT_LAST;
                    win_if_d = pick_if;
                    mem_en_d = 1'b1;
                    busy_d   = 1'b1;
                    if (pick_if) begin
                        if_gnt_d   = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = bus.if_addr;
                        mem_be_d   = 4'b1111;
                        starve_d   = '0;
                    end else begin
                        dm_gnt_d    = 1'b1;
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                        mem_be_d    = bus.dm_be;
                        if (bus.if_req && starve_q != STARVE_MAX) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            ACCESS: begin
                if (lat_q == '0) begin
                    // Read data is only valid at the end of the last enable cycle.
                    if (win_if_q) begin
                        if_rdata_d = bus.mem_rdata;
                    end else if (!bus.mem_we) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                    if_done_d = win_if_q;
                    dm_done_d = !win_if_q;
                    mem_en_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = RESP;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            lat_q         <= '0;
            starve_q      <= '0;
            win_if_q      <= 1'b0;
            bus.if_gnt    <= 1'b0;
            bus.dm_gnt    <= 1'b0;
            bus.if_done   <= 1'b0;
            bus.dm_done   <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_q         <= lat_d;
            starve_q      <= starve_d;
            win_if_q      <= win_if_d;
            bus.if_gnt    <= if_gnt_d;
            bus.dm_gnt    <= dm_gnt_d;
            bus.if_done   <= if_done_d;
            bus.dm_done   <= dm_done_d;
            bus.mem_en    <= mem_en_d;
            bus.mem_we    <= mem_we_d;
            bus.mem_addr  <= mem_addr_d;
            bus.mem_wdata <= mem_wdata_d;
            bus.mem_be    <= mem_be_d;
            bus.if_rdata  <= if_rdata_d;
            bus.dm_rdata  <= dm_rdata_d;
            bus.busy      <= busy_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a cycle-numbered transaction model
// checks every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int SLIM  = 4;
    localparam int LAT2  = 1;
    localparam int SLIM2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if2 ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) u_dut (
        .clk(clk), .rst(rst), .bus(u_if.slave)
    );
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT2), .STARVE_LIMIT(SLIM2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(u_if2.slave)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic want);
        check(name, {31'b0, got}, {31'b0, want});
    endtask

    function automatic logic [31:0] mem_word(input int i);
        if (i == 0) return 32'h2008_0005;
        if (i == 1) return 32'h1122_3344;
        return 32'h9E37_79B1 * i + 32'h0101_0101;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Memory array seen by the DUT: 64 words, combinational read, byte-enabled write.
    logic [31:0] phys_mem [64];
    assign u_if.mem_rdata  = phys_mem[u_if.mem_addr[7:2]];
    assign u_if2.mem_rdata = {u_if2.mem_addr[15:0], 16'hC0DE};

    initial begin
        for (int i = 0; i < 64; i++) phys_mem[i] = mem_word(i);
        forever begin
            @(posedge clk);
            if (u_if.mem_en && u_if.mem_we)
                phys_mem[u_if.mem_addr[7:2]] = merge(phys_mem[u_if.mem_addr[7:2]], u_if.mem_wdata, u_if.mem_be);
        end
    end

    // Reference model: an access granted for cycle s occupies cycles s..s+LAT (enable for LAT
    // cycles, done in s+LAT); the next decision is taken at the edge ending cycle s+LAT+1.
    logic [31:0] ref_mem [64];
    int          m_cyc = 0;
    int          m_start = 0;
    bit          m_active = 0;
    bit          m_win_if = 0;
    bit          m_we = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be = '0;
    int          m_starve = 0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_dm_rdata = '0;

    initial begin
        int c;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem_word(i);
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_active = 0; m_starve = 0; m_cyc = 0;
                m_if_rdata = '0; m_dm_rdata = '0;
            end else begin
                c = m_cyc;
                if (m_active && c == m_start + LAT - 1) begin
                    if (m_win_if)  m_if_rdata = ref_mem[m_addr[7:2]];
                    else if (m_we) ref_mem[m_addr[7:2]] = merge(ref_mem[m_addr[7:2]], m_wdata, m_be);
                    else           m_dm_rdata = ref_mem[m_addr[7:2]];
                end else if (m_active && c == m_start + LAT) begin
                    m_active = 0;
                end else if (!m_active && (u_if.if_req || u_if.dm_req)) begin
                    m_win_if = u_if.if_req && (!u_if.dm_req || m_starve == SLIM);
                    m_start  = c + 1;
                    m_active = 1;
                    if (m_win_if) begin
                        m_addr = u_if.if_addr; m_we = 0; m_be = 4'hF; m_starve = 0;
                    end else begin
                        m_addr = u_if.dm_addr; m_we = u_if.dm_we; m_wdata = u_if.dm_wdata; m_be = u_if.dm_be;
                        if (u_if.if_req) m_starve = (m_starve >= SLIM) ? SLIM : m_starve + 1;
                    end
                end
                m_cyc = c + 1;
            end
        end
    end

    initial begin
        int k;
        bit en_e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                k    = m_cyc;
                en_e = m_active && (k < m_start + LAT);
                chk_bit("if_gnt",  u_if.if_gnt,  m_active && k == m_start && m_win_if);
                chk_bit("dm_gnt",  u_if.dm_gnt,  m_active && k == m_start && !m_win_if);
                chk_bit("if_done", u_if.if_done, m_active && k == m_start + LAT && m_win_if);
                chk_bit("dm_done", u_if.dm_done, m_active && k == m_start + LAT && !m_win_if);
                chk_bit("mem_en",  u_if.mem_en,  en_e);
                chk_bit("mem_we",  u_if.mem_we,  en_e && m_we);
                chk_bit("busy",    u_if.busy,    m_active);
                check("if_rdata", u_if.if_rdata, m_if_rdata);
                check("dm_rdata", u_if.dm_rdata, m_dm_rdata);
                if (en_e) begin
                    check("mem_addr", u_if.mem_addr, m_addr);
                    check("mem_be", {28'b0, u_if.mem_be}, {28'b0, m_be});
                    if (m_we) check("mem_wdata", u_if.mem_wdata, m_wdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic dm_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output bit done, output bit gnt_we, output logic [3:0] gnt_be);
        done = 0; gnt_we = 0; gnt_be = '0;
        u_if.dm_we = we; u_if.dm_addr = addr; u_if.dm_wdata = wdata; u_if.dm_be = be; u_if.dm_req = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (u_if.dm_gnt) begin gnt_we = u_if.mem_we; gnt_be = u_if.mem_be; end
            if (u_if.dm_done) done = 1;
        end
        @(posedge clk); #2 u_if.dm_req = 1'b0;
    endtask

    task automatic if_access(input logic [31:0] addr, output bit done);
        done = 0;
        u_if.if_addr = addr; u_if.if_req = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (u_if.if_done) done = 1;
        end
        @(posedge clk); #2 u_if.if_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!u_if.busy) break;
        end
        chk_bit("idle_reached", u_if.busy, 1'b0);
    endtask

    task automatic fetch_agent(input int n);
        for (int i = 0; i < n; i++) begin
            bit granted, done;
            granted = 0; done = 0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2;
            u_if.if_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            u_if.if_req  = 1'b1;
            for (int c = 0; c < 100 && !done; c++) begin
                @(negedge clk);
                if (u_if.if_done) done = 1;
                else begin
                    if (u_if.if_gnt) granted = 1;
                    if (granted && $urandom_range(0, 7) == 0) begin
                        u_if.if_req = 1'b0; u_if.if_addr = $urandom;
                    end
                end
            end
            chk_bit("fetch_handshake", done, 1'b1);
            @(posedge clk); #2 u_if.if_req = 1'b0;
        end
    endtask

    task automatic dm_agent(input int n);
        for (int i = 0; i < n; i++) begin
            bit granted, done;
            granted = 0; done = 0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #2;
            u_if.dm_we    = 1'($urandom_range(0, 1));
            u_if.dm_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            u_if.dm_wdata = $urandom;
            u_if.dm_be    = 4'($urandom_range(1, 15));
            u_if.dm_req   = 1'b1;
            for (int c = 0; c < 100 && !done; c++) begin
                @(negedge clk);
                if (u_if.dm_done) done = 1;
                else begin
                    if (u_if.dm_gnt) granted = 1;
                    if (granted && $urandom_range(0, 5) == 0) begin
                        u_if.dm_req = 1'b0; u_if.dm_addr = $urandom; u_if.dm_wdata = $urandom;
                        u_if.dm_be = 4'($urandom); u_if.dm_we = 1'($urandom);
                    end
                end
            end
            chk_bit("dm_handshake", done, 1'b1);
            @(posedge clk); #2 u_if.dm_req = 1'b0;
        end
    endtask

    bit exp_starve[6] = '{0, 0, 0, 0, 1, 0};
    bit exp_l1[6]     = '{0, 0, 1, 0, 0, 1};

    initial begin
        bit          ok, gwe;
        logic [3:0]  gbe;
        bit          order[6];
        int          n, last_gnt;

        u_if.if_req = 0; u_if.if_addr = '0; u_if.dm_req = 0; u_if.dm_we = 0;
        u_if.dm_addr = '0; u_if.dm_wdata = '0; u_if.dm_be = '0;
        u_if2.if_req = 0; u_if2.if_addr = '0; u_if2.dm_req = 0; u_if2.dm_we = 0;
        u_if2.dm_addr = '0; u_if2.dm_wdata = '0; u_if2.dm_be = '0;

        // Reset state.
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_bit("reset_mem_en", u_if.mem_en, 1'b0);
        chk_bit("reset_busy", u_if.busy, 1'b0);
        chk_bit("reset_gnt", u_if.if_gnt | u_if.dm_gnt, 1'b0);
        chk_bit("reset_done", u_if.if_done | u_if.dm_done, 1'b0);
        check("reset_if_rdata", u_if.if_rdata, 32'h0);
        check("reset_dm_rdata", u_if.dm_rdata, 32'h0);
        check("reset_mem_addr", u_if.mem_addr, 32'h0);
        @(posedge clk); #2 rst = 1'b1;

        // Single fetch with literal cycle-by-cycle expectations (this is cycle 0).
        u_if.if_addr = 32'h3000; u_if.if_req = 1'b1;
        @(negedge clk);
        chk_bit("f_c0_gnt", u_if.if_gnt, 1'b0);
        @(negedge clk);
        chk_bit("f_c1_gnt", u_if.if_gnt, 1'b1);
        chk_bit("f_c1_en", u_if.mem_en, 1'b1);
        check("f_c1_be", {28'b0, u_if.mem_be}, 32'hF);
        check("f_c1_addr", u_if.mem_addr, 32'h3000);
        @(negedge clk);
        chk_bit("f_c2_en", u_if.mem_en, 1'b1);
        chk_bit("f_c2_done", u_if.if_done, 1'b0);
        @(negedge clk);
        chk_bit("f_c3_done", u_if.if_done, 1'b1);
        chk_bit("f_c3_en", u_if.mem_en, 1'b0);
        check("f_c3_rdata", u_if.if_rdata, 32'h2008_0005);
        @(posedge clk); #2 u_if.if_req = 1'b0;
        @(negedge clk);
        chk_bit("f_c4_busy", u_if.busy, 1'b0);

        // Store then load of the merged word.
        @(posedge clk); #2;
        dm_access(1'b1, 32'h4, 32'hDEAD_BEEF, 4'b0011, ok, gwe, gbe);
        chk_bit("store_done", ok, 1'b1);
        chk_bit("store_mem_we", gwe, 1'b1);
        check("store_mem_be", {28'b0, gbe}, 32'h3);
        check("store_keeps_dm_rdata", u_if.dm_rdata, 32'h0);
        dm_access(1'b0, 32'h4, 32'h0, 4'hF, ok, gwe, gbe);
        chk_bit("load_done", ok, 1'b1);
        chk_bit("load_mem_we", gwe, 1'b0);
        check("load_merged", u_if.dm_rdata, 32'h1122_BEEF);

        // Both requests held: fetch is forced in after STARVE_LIMIT losses.
        u_if.if_addr = 32'h3000; u_if.dm_we = 1'b0; u_if.dm_addr = 32'h4;
        u_if.if_req = 1'b1; u_if.dm_req = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 6; c++) begin
            @(negedge clk);
            if (u_if.if_gnt) begin order[n] = 1; n++; end
            else if (u_if.dm_gnt) begin order[n] = 0; n++; end
        end
        check("starve_grant_count", n, 6);
        @(posedge clk); #2 u_if.if_req = 1'b0; u_if.dm_req = 1'b0;
        for (int i = 0; i < 6 && i < n; i++) chk_bit($sformatf("starve_order%0d", i), order[i], exp_starve[i]);
        wait_idle();

        // Reset asserted in the second ACCESS cycle of a fetch.
        @(posedge clk); #2 u_if.if_addr = 32'h3000; u_if.if_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_bit("rst_pre_gnt", u_if.if_gnt, 1'b1);
        @(negedge clk);
        chk_bit("rst_pre_en", u_if.mem_en, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk_bit("rst_mem_en", u_if.mem_en, 1'b0);
        chk_bit("rst_mem_we", u_if.mem_we, 1'b0);
        chk_bit("rst_busy", u_if.busy, 1'b0);
        check("rst_if_rdata", u_if.if_rdata, 32'h0);
        check("rst_dm_rdata", u_if.dm_rdata, 32'h0);
        check("rst_mem_addr", u_if.mem_addr, 32'h0);
        u_if.if_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_bit("rst_no_done", u_if.if_done, 1'b0);
        end
        @(posedge clk); #2 rst = 1'b1;
        if_access(32'h3000, ok);
        chk_bit("post_rst_done", ok, 1'b1);
        check("post_rst_rdata", u_if.if_rdata, 32'h2008_0005);

        // dm_req dropped in the first ACCESS cycle of a load.
        u_if.dm_we = 1'b0; u_if.dm_addr = 32'h8; u_if.dm_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_bit("drop_gnt", u_if.dm_gnt, 1'b1);
        u_if.dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_bit("drop_done", u_if.dm_done, 1'b1);
        check("drop_rdata", u_if.dm_rdata, mem_word(2));
        repeat (2) begin
            @(negedge clk);
            chk_bit("drop_idle_busy", u_if.busy, 1'b0);
            chk_bit("drop_no_gnt", u_if.if_gnt | u_if.dm_gnt, 1'b0);
        end

        // Randomized traffic from both requesters against the model.
        fork
            fetch_agent(60);
            dm_agent(60);
        join
        wait_idle();

        // MEM_LATENCY=1, STARVE_LIMIT=2 instance with both requests held.
        @(posedge clk); #2;
        u_if2.if_addr = 32'h40; u_if2.dm_addr = 32'h80; u_if2.if_req = 1'b1; u_if2.dm_req = 1'b1;
        n = 0; last_gnt = -10;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if (c == last_gnt + 1) chk_bit("l1_done_next", u_if2.if_done | u_if2.dm_done, 1'b1);
            if (u_if2.if_gnt || u_if2.dm_gnt) begin
                if (n == 0) check("l1_first_gnt", c, 1);
                else        check("l1_gnt_gap", c - last_gnt, 3);
                chk_bit($sformatf("l1_order%0d", n), u_if2.if_gnt, exp_l1[n]);
                last_gnt = c;
                n++;
            end
        end
        check("l1_grant_count", n, 6);
        @(posedge clk); #2 u_if2.if_req = 1'b0; u_if2.dm_req = 1'b0;
        repeat (4) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
